// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV64 subset datapath (ld, sd, beq, add, sub, and, or).
// Define MULTICYCLE_PERF_EN to add the cycle_cnt / instr_cnt performance counters.
//
//   state     | meaning
//   IDLE      | waiting for run; all controls low
//   FETCH     | IR <= mem[PC], PC <= PC+4 once mem_ready
//   DECODE    | branch target into ALUOut, dispatch on opcode
//   MEM_ADDR  | rs1 + imm into ALUOut
//   MEM_READ  | load data read, held until mem_ready
//   LD_WB     | MDR into rd
//   MEM_WRITE | store, held until mem_ready
//   R_EXEC    | rs1 op rs2 into ALUOut
//   R_WB      | ALUOut into rd
//   BRANCH    | compare rs1/rs2, conditional PC <= ALUOut
//   TRAP      | unsupported opcode; parked until reset
module multicycle_control #(
  parameter int         STATE_W    = 4,
  parameter logic [1:0] PC_INC_SEL = 2'b01
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_operation,
  output logic               pc_source,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instr_cnt
`endif
);

  localparam logic [STATE_W-1:0] S_IDLE      = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_FETCH     = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_DECODE    = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEM_ADDR  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEM_READ  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_LD_WB     = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_MEM_WRITE = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_R_EXEC    = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_R_WB      = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BRANCH    = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_TRAP      = STATE_W'(10);

  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  logic [STATE_W-1:0] state_q, state_d;
  logic               illegal_q, illegal_d;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE:      if (run) state_d = S_FETCH;
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LD, OP_SD: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_LD_WB;
      S_LD_WB:     state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_operation = 2'b00;
    pc_source     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = PC_INC_SEL;
        // IR and PC load only on the cycle the fetch actually completes
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:    alu_src_b = 2'b10;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_LD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a     = 1'b1;
        alu_operation = 2'b10;
      end
      S_R_WB:      reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_operation = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
  assign state_o = state_q;

`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic        retire;

  always_comb begin
    retire = (state_d == S_FETCH) &&
             ((state_q == S_LD_WB) || (state_q == S_MEM_WRITE) ||
              (state_q == S_R_WB)  || (state_q == S_BRANCH));
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if ((state_q != S_IDLE) && (state_q != S_TRAP)) cycle_cnt_d = cycle_cnt_q + 32'd1;
    if (retire) instr_cnt_d = instr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule
